perf_event_monitor: RTL and testbench

- Synthesizable cycle/event counter bank for the pipelined CPU.
- Counts active cycles plus NUM_EVT qualified event lines, such as stall, flush, branch-taken and load-use, while the CPU is started.
- Freezes automatically after a programmable cycle budget.
- Exposes every counter through a one-cycle-latency read port, so benches and on-chip debug logic read statistics without hierarchical probing.

---
 rtl/perf_pkg.sv | 13 +
 rtl/perf_event_monitor_sat_counter.sv | 36 +++
 rtl/perf_event_monitor.sv | 118 +++++++++++
 tb/tb_perf_event_monitor.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared types and constants for the performance event monitor.
package perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } perf_state_e;

    localparam int CH_CYCLE = 0;
    localparam int SEL_W    = 4;

endpackage

// File: rtl/perf_event_monitor_sat_counter.sv
// Saturating up-counter with a sticky overflow flag; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_value,
    output logic             o_ovf
);

    logic [CNT_W-1:0] r_value;
    logic             r_ovf;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_value <= '0;
            r_ovf   <= 1'b0;
        end else if (i_clr) begin
            r_value <= '0;
            r_ovf   <= 1'b0;
        end else if (i_inc) begin
            // At all-ones the value holds and the attempt is recorded instead.
            if (&r_value) begin
                r_ovf <= 1'b1;
            end else begin
                r_value <= r_value + CNT_W'(1);
            end
        end
    end

    assign o_value = r_value;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/perf_event_monitor.sv
// Cycle/event counter bank with run/pause/auto-freeze control and a registered read port.
module perf_event_monitor
    import perf_pkg::*;
#(
    parameter int              NUM_EVT    = 4,
    parameter int              CNT_W      = 32,
    parameter longint unsigned MAX_CYCLES = 30
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               clear_i,
    input  logic               rd_en_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic               rd_valid_o,
    output logic               running_o,
    output logic               done_o,
    output logic [NUM_EVT:0]   ovf_o
);

    if (NUM_EVT < 1 || NUM_EVT > 15) begin : g_bad_num_evt
        $error("NUM_EVT must be in 1..15");
    end
    if (CNT_W < 8 || CNT_W > 64) begin : g_bad_cnt_w
        $error("CNT_W must be in 8..64");
    end
    if (CNT_W < 64 && (MAX_CYCLES >> CNT_W) != 0) begin : g_bad_budget
        $error("MAX_CYCLES must fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] LP_BUDGET = CNT_W'(MAX_CYCLES);

    perf_state_e      r_state;
    logic [CNT_W-1:0] r_rd_data;
    logic             r_rd_valid;

    logic [CNT_W-1:0] w_cnt [NUM_EVT+1];
    logic [NUM_EVT:0] w_ovf;
    logic             w_cnt_en;
    logic [CNT_W-1:0] w_cyc_next;
    logic             w_budget_hit;
    logic [CNT_W-1:0] w_rd_mux;

    // Every edge spent in RUN counts, including the pause edge and the freeze edge.
    assign w_cnt_en     = (r_state == ST_RUN) && !clear_i;
    assign w_cyc_next   = w_cnt[CH_CYCLE] + CNT_W'(1);
    assign w_budget_hit = (MAX_CYCLES != 0) && (w_cyc_next == LP_BUDGET);

    for (genvar g = 0; g <= NUM_EVT; g++) begin : g_ch
        logic w_inc;
        if (g == CH_CYCLE) begin : g_cyc
            assign w_inc = w_cnt_en;
        end else begin : g_evt
            assign w_inc = w_cnt_en & evt_i[g-1];
        end

        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .i_clk   (clk_i),
            .i_rst_n (rst_i),
            .i_clr   (clear_i),
            .i_inc   (w_inc),
            .o_value (w_cnt[g]),
            .o_ovf   (w_ovf[g])
        );
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else if (clear_i) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start_i) r_state <= ST_RUN;
                ST_RUN: begin
                    if (w_budget_hit) begin
                        r_state <= ST_DONE;
                    end else if (!start_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DONE: r_state <= ST_DONE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Unimplemented selects read back as zero.
    always_comb begin
        w_rd_mux = '0;
        for (int k = 0; k <= NUM_EVT; k++) begin
            if (rd_sel_i == SEL_W'(k)) begin
                w_rd_mux = w_cnt[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en_i;
            if (rd_en_i) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign rd_data_o  = r_rd_data;
    assign rd_valid_o = r_rd_valid;
    assign running_o  = (r_state == ST_RUN);
    assign done_o     = (r_state == ST_DONE);
    assign ovf_o      = w_ovf;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Bench for perf_event_monitor: a 32-bit/budget-30 instance and an 8-bit/unlimited instance share stimulus.
module tb_perf_event_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] evt = '0;
  logic       clear = 1'b0;
  logic       rd_en = 1'b0;
  logic [3:0] rd_sel = '0;

  logic [31:0] rd_data_a;
  logic        rd_valid_a, running_a, done_a;
  logic [4:0]  ovf_a;
  logic [7:0]  rd_data_b;
  logic        rd_valid_b, running_b, done_b;
  logic [4:0]  ovf_b;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  perf_event_monitor #(.NUM_EVT(4), .CNT_W(32), .MAX_CYCLES(30)) u_dut_a (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .evt_i(evt), .clear_i(clear),
    .rd_en_i(rd_en), .rd_sel_i(rd_sel), .rd_data_o(rd_data_a), .rd_valid_o(rd_valid_a),
    .running_o(running_a), .done_o(done_a), .ovf_o(ovf_a)
  );

  perf_event_monitor #(.NUM_EVT(4), .CNT_W(8), .MAX_CYCLES(0)) u_dut_b (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .evt_i(evt), .clear_i(clear),
    .rd_en_i(rd_en), .rd_sel_i(rd_sel), .rd_data_o(rd_data_b), .rd_valid_o(rd_valid_b),
    .running_o(running_b), .done_o(done_b), .ovf_o(ovf_b)
  );

  // Reference model: index 0 mirrors u_dut_a, index 1 mirrors u_dut_b.
  longint unsigned cnt_max[2] = '{64'hFFFF_FFFF, 64'd255};
  longint unsigned budget[2]  = '{64'd30, 64'd0};
  longint unsigned m_cnt[2][5];
  logic [4:0]      m_ovf[2];
  bit              m_run[2];
  bit              m_done[2];
  longint unsigned m_rd[2];
  bit              m_rv[2];

  initial begin
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 5; k++) m_cnt[c][k] = 0;
      m_ovf[c] = '0; m_run[c] = 0; m_done[c] = 0; m_rd[c] = 0; m_rv[c] = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        for (int k = 0; k < 5; k++) m_cnt[c][k] = 0;
        m_ovf[c] = '0; m_run[c] = 0; m_done[c] = 0; m_rd[c] = 0; m_rv[c] = 0;
      end else begin
        m_rv[c] = rd_en;
        if (rd_en) m_rd[c] = (rd_sel <= 4) ? m_cnt[c][rd_sel] : 0;
        if (clear) begin
          for (int k = 0; k < 5; k++) m_cnt[c][k] = 0;
          m_ovf[c] = '0; m_run[c] = 0; m_done[c] = 0;
        end else if (m_run[c]) begin
          for (int k = 0; k < 5; k++) begin
            bit hit;
            if (k == 0) hit = 1'b1;
            else hit = evt[k-1];
            if (hit) begin
              if (m_cnt[c][k] == cnt_max[c]) m_ovf[c][k] = 1'b1;
              else m_cnt[c][k] = m_cnt[c][k] + 1;
            end
          end
          if (budget[c] != 0 && m_cnt[c][0] == budget[c]) begin
            m_run[c] = 0; m_done[c] = 1;
          end else if (!start) begin
            m_run[c] = 0;
          end
        end else if (!m_done[c] && start) begin
          m_run[c] = 1;
        end
      end
    end
  end

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("running_a", running_a, m_run[0]);
    check("done_a", done_a, m_done[0]);
    check("ovf_a", ovf_a, m_ovf[0]);
    check("rd_valid_a", rd_valid_a, m_rv[0]);
    check("rd_data_a", rd_data_a, m_rd[0]);
    check("running_b", running_b, m_run[1]);
    check("done_b", done_b, m_done[1]);
    check("ovf_b", ovf_b, m_ovf[1]);
    check("rd_valid_b", rd_valid_b, m_rv[1]);
    check("rd_data_b", rd_data_b, m_rd[1]);
  end

  task automatic do_read(input logic [3:0] sel, output longint unsigned a, output longint unsigned b);
    rd_en = 1'b1;
    rd_sel = sel;
    @(negedge clk);
    a = rd_data_a;
    b = rd_data_b;
    check("read_valid_pulse", rd_valid_a, 1);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned ra, rb;

    repeat (2) @(negedge clk);
    check("reset_running", running_a, 0);
    check("reset_done", done_a, 0);
    check("reset_ovf", ovf_a, 0);
    check("reset_rd_valid", rd_valid_a, 0);
    check("reset_rd_data", rd_data_a, 0);
    rst_n = 1'b1;
    pulse_clear();

    // Budget stop: 30 counting edges, evt[0] on every 3rd one.
    start = 1'b1;
    @(negedge clk);
    for (int j = 1; j <= 40; j++) begin
      evt = {3'b000, (j % 3 == 0)};
      @(negedge clk);
      if (j == 29) check("budget_not_done_29", done_a, 0);
      if (j == 30) check("budget_done_30", done_a, 1);
    end
    evt = '0;
    do_read(4'd0, ra, rb);
    check("budget_ch0", ra, 30);
    do_read(4'd1, ra, rb);
    check("budget_ch1", ra, 10);
    check("budget_frozen_running", running_a, 0);

    // Pause/resume with evt[1] constantly high.
    start = 1'b0;
    pulse_clear();
    evt = 4'b0010;
    start = 1'b1; repeat (5) @(negedge clk);
    start = 1'b0; repeat (4) @(negedge clk);
    start = 1'b1; repeat (6) @(negedge clk);
    start = 1'b0; repeat (2) @(negedge clk);
    evt = '0;
    do_read(4'd0, ra, rb);
    check("pause_ch0", ra, 11);
    do_read(4'd2, ra, rb);
    check("pause_ch2", ra, 11);

    // Read timing: read issued while the cycle counter is 7 and incrementing.
    pulse_clear();
    start = 1'b1;
    @(negedge clk);
    repeat (7) @(negedge clk);
    do_read(4'd0, ra, rb);
    check("read_pre_increment", ra, 7);
    @(negedge clk);
    check("read_valid_one_cycle", rd_valid_a, 0);
    check("read_data_holds", rd_data_a, 7);
    do_read(4'd9, ra, rb);
    check("read_sel_out_of_range", ra, 0);

    // Clear priority over start and events while running.
    check("clear_pre_running", running_a, 1);
    clear = 1'b1; evt = 4'hF;
    @(negedge clk);
    clear = 1'b0; evt = '0;
    check("clear_forces_idle", running_a, 0);
    check("clear_ovf", ovf_a, 0);
    do_read(4'd0, ra, rb);
    check("clear_ch0_zero", ra, 0);
    check("clear_rerun", running_a, 1);

    // Saturation on the 8-bit instance.
    start = 1'b0;
    pulse_clear();
    start = 1'b1;
    @(negedge clk);
    for (int j = 1; j <= 300; j++) begin
      @(negedge clk);
      if (j == 255) check("sat_no_ovf_255", ovf_b[0], 0);
      if (j == 256) check("sat_ovf_256", ovf_b[0], 1);
    end
    start = 1'b0;
    @(negedge clk);
    do_read(4'd0, ra, rb);
    check("sat_ch0", rb, 255);
    pulse_clear();
    check("sat_clear_ovf", ovf_b, 0);
    do_read(4'd0, ra, rb);
    check("sat_clear_ch0", rb, 0);

    // Asynchronous reset mid-run.
    start = 1'b1;
    repeat (11) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_running_a", running_a, 0);
    check("async_rst_running_b", running_b, 0);
    check("async_rst_ovf", ovf_a, 0);
    start = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    do_read(4'd0, ra, rb);
    check("rst_ch0_a", ra, 0);
    check("rst_ch0_b", rb, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      start  = ($urandom_range(0, 7) != 0);
      evt    = 4'($urandom_range(0, 15));
      clear  = ($urandom_range(0, 63) == 0);
      rd_en  = ($urandom_range(0, 1) == 1);
      rd_sel = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    start = 1'b0; evt = '0; clear = 1'b0; rd_en = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
